// File: rtl/cdc_pkg.sv
// Shared definitions for the clkA -> clkB handshake crossing.
// The sender (cdc_hs_tx) and the clkB receiver both import this package,
// so the state encoding and default widths stay consistent on both sides.
package cdc_pkg;

  // Handshake sender states: waiting for a word, request raised, request dropped
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } cdc_state_e;

  localparam int CDC_DATA_W      = 2;
  localparam int CDC_SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit level synchroniser: a plain chain of STAGES flops.
// Used for the returning ack on the sender side and for req on the receiver.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous level through the chain; reset forces all stages low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source-side 4-phase handshake sender for the clkA -> clkB data crossing.
// A word accepted over valid/ready is held on xfer_data while xfer_req is
// raised; the synchronised ack drops req, and its fall completes the transfer.
// A sticky timeout flag reports handshakes that take too long, but the
// handshake itself is never abandoned except by reset.
module cdc_hs_tx
  import cdc_pkg::*;
#(
  parameter int DATA_W      = CDC_DATA_W,
  parameter int SYNC_STAGES = CDC_SYNC_STAGES,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clkA,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] xfer_data,
  output logic              xfer_req,
  input  logic              ack_async,
  output logic              xfer_done,
  output logic              timeout_err
);

  // A zero timeout disables the counter; keep at least one bit so widths stay legal
  localparam int              CNT_W      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT_CYC);
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYC > 0);

  cdc_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              ack_s;
  logic              accept;

  // The ack level comes from the clkB domain; this is its only entry point
  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clkA),
    .reset (reset),
    .d_i   (ack_async),
    .q_o   (ack_s)
  );

  // Handshake FSM next-state, held word and request level; a stale high ack blocks acceptance
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    data_d   = data_q;
    done_d   = 1'b0;
    in_ready = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !ack_s;
        if (in_valid && !ack_s) begin
          accept  = 1'b1;
          data_d  = in_data;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = DROP;
        end
      end
      DROP: begin
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Timeout counter restarts on accept, counts busy cycles and saturates; the flag is sticky
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if ((state_q != IDLE) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    err_d = err_q | (TIMEOUT_EN && (cnt_d == CNT_MAX));
  end

  // All state and registered outputs; reset drops req at once and abandons any word in flight
  always_ff @(posedge clkA or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign xfer_req    = req_q;
  assign xfer_data   = data_q;
  assign xfer_done   = done_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Self-checking bench for cdc_hs_tx with SYNC_STAGES = 2 and TIMEOUT_CYC = 8.
// Words are pushed to a scoreboard when the bench expects acceptance and
// popped when xfer_req rises. Inputs change and outputs are sampled on the
// falling edge of clkA, half a cycle away from the active edge.
module tb_cdc_hs_tx;

  logic       clkA;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_data;
  logic [1:0] xfer_data;
  logic       xfer_req;
  logic       ack_async;
  logic       xfer_done;
  logic       timeout_err;

  int         checkCount;
  int         passCount;
  logic [1:0] expQ[$];
  logic       reqPrev;

  cdc_hs_tx #(
    .DATA_W      (2),
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (8)
  ) dut (
    .clkA        (clkA),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .xfer_data   (xfer_data),
    .xfer_req    (xfer_req),
    .ack_async   (ack_async),
    .xfer_done   (xfer_done),
    .timeout_err (timeout_err)
  );

  // Free-running source clock, 10 time units per cycle
  initial clkA = 1'b0;
  always #5 clkA = ~clkA;

  // Single comparison point: counts every check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one upstream beat; when an accept is expected, record the word
  task automatic applyStimulus(input logic v, input logic [1:0] d, input logic expectAccept);
    in_valid = v;
    in_data  = d;
    #1;
    if (v) begin
      checkOutput(expectAccept ? "ready_accept" : "ready_busy", in_ready, expectAccept);
    end
    if (v && expectAccept) begin
      expQ.push_back(d);
    end
  endtask

  // Model clkB receiver: ack a few cycles after req, release a few cycles after req falls
  task automatic runHandshake();
    int waitCnt;
    waitCnt = 0;
    while (!xfer_req && waitCnt < 20) begin
      @(negedge clkA);
      waitCnt++;
    end
    checkOutput("hs_req_seen", xfer_req, 1);
    repeat (2) @(negedge clkA);
    ack_async = 1'b1;
    waitCnt = 0;
    while (xfer_req && waitCnt < 20) begin
      @(negedge clkA);
      waitCnt++;
    end
    checkOutput("hs_req_drop", xfer_req, 0);
    repeat (2) @(negedge clkA);
    ack_async = 1'b0;
    waitCnt = 0;
    while (!xfer_done && waitCnt < 20) begin
      @(negedge clkA);
      waitCnt++;
    end
    checkOutput("hs_done", xfer_done, 1);
    @(negedge clkA);
  endtask

  // Scoreboard side: every new request must present the oldest expected word
  initial reqPrev = 1'b0;
  always @(negedge clkA) begin
    if (reset && xfer_req && !reqPrev) begin
      if (expQ.size() == 0) begin
        checkOutput("sb_unexpected_req", 1, 0);
      end else begin
        checkOutput("sb_xfer_data", xfer_data, expQ.pop_front());
      end
    end
    reqPrev = xfer_req;
  end

  // Hard stop in case a handshake never completes
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: basic transfer with exact timing, timeout, reset mid-handshake
  initial begin
    logic [1:0] rnd;
    checkCount = 0;
    passCount  = 0;
    reset      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 2'b00;
    ack_async  = 1'b0;
    repeat (3) @(negedge clkA);

    checkOutput("rst_req", xfer_req, 0);
    checkOutput("rst_data", xfer_data, 0);
    checkOutput("rst_done", xfer_done, 0);
    checkOutput("rst_err", timeout_err, 0);
    checkOutput("rst_ready", in_ready, 1);
    reset = 1'b1;
    @(negedge clkA);

    // First word accepted at the next edge
    $display("[TB] basic transfer with fixed receiver timing");
    applyStimulus(1'b1, 2'b10, 1'b1);
    @(negedge clkA);
    checkOutput("req_after_accept", xfer_req, 1);
    checkOutput("data_after_accept", xfer_data, 2'b10);

    // Busy window: ack rises before the 3rd edge after accept, falls 3 edges after req drops
    for (int n = 1; n <= 10; n++) begin
      if (n == 3) ack_async = 1'b1;
      if (n == 8) ack_async = 1'b0;
      checkOutput("req_level", xfer_req, (n <= 5));
      checkOutput("done_idle", xfer_done, 0);
      checkOutput("data_hold", xfer_data, 2'b10);
      rnd = 2'($urandom_range(0, 3));
      applyStimulus(1'b1, rnd, 1'b0);
      @(negedge clkA);
    end

    // Done cycle: pulse visible and the next word is taken in the same cycle
    checkOutput("done_pulse", xfer_done, 1);
    applyStimulus(1'b1, 2'b01, 1'b1);
    @(negedge clkA);
    checkOutput("done_one_cycle", xfer_done, 0);
    checkOutput("req_second", xfer_req, 1);
    checkOutput("data_second", xfer_data, 2'b01);
    in_valid = 1'b0;
    runHandshake();
    checkOutput("data_after_second", xfer_data, 2'b01);
    repeat (2) @(negedge clkA);

    // Timeout: ack held low, flag sets 8 cycles after accept and sticks
    $display("[TB] timeout with stalled receiver");
    reset = 1'b0;
    #1;
    checkOutput("rst_clears_err", timeout_err, 0);
    @(negedge clkA);
    reset = 1'b1;
    @(negedge clkA);
    applyStimulus(1'b1, 2'b00, 1'b1);
    @(negedge clkA);
    in_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      checkOutput("err_before_limit", timeout_err, 0);
      @(negedge clkA);
    end
    checkOutput("err_at_limit", timeout_err, 1);
    checkOutput("req_not_aborted", xfer_req, 1);
    runHandshake();
    checkOutput("err_sticky", timeout_err, 1);
    repeat (3) @(negedge clkA);
    checkOutput("err_still_sticky", timeout_err, 1);
    reset = 1'b0;
    #1;
    checkOutput("err_reset", timeout_err, 0);
    @(negedge clkA);
    reset = 1'b1;
    @(negedge clkA);

    // Reset while in REQ with ack high: req drops at once, stale ack blocks acceptance
    $display("[TB] reset during handshake with stale ack");
    applyStimulus(1'b1, 2'b10, 1'b1);
    @(negedge clkA);
    in_valid  = 1'b0;
    checkOutput("req_before_reset", xfer_req, 1);
    ack_async = 1'b1;
    @(negedge clkA);
    checkOutput("req_still_high", xfer_req, 1);
    reset = 1'b0;
    #1;
    checkOutput("req_async_drop", xfer_req, 0);
    @(negedge clkA);
    reset = 1'b1;
    repeat (2) @(negedge clkA);
    for (int n = 0; n < 4; n++) begin
      checkOutput("ready_stale_ack", in_ready, 0);
      @(negedge clkA);
    end
    ack_async = 1'b0;
    @(negedge clkA);
    checkOutput("ready_ack_falling", in_ready, 0);
    @(negedge clkA);
    checkOutput("ready_after_sync", in_ready, 1);
    applyStimulus(1'b1, 2'b11, 1'b1);
    @(negedge clkA);
    in_valid = 1'b0;
    checkOutput("data_final", xfer_data, 2'b11);
    runHandshake();
    checkOutput("sb_drained", expQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
